// File: rtl/bram_port_arbiter_pkg.sv
// ============================================================================
// Package : bram_arb_pkg
// Brief   : Shared types and helpers for the BRAM port arbiter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package bram_arb_pkg;

    typedef enum logic [0:0] {ST_CLEAR, ST_RUN} arb_state_t;

    // Round-robin successor: g+1 wrapped to 0 at n.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g + 32'd1 >= n) ? 32'd0 : g + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_port_arbiter_if.sv
// ============================================================================
// Interface : bram_port_arbiter_if
// Brief     : Requester handshake, response and memory-port bundle.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface bram_port_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 1
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic [ADDR_W-1:0]         mem_raddr;
    logic [ADDR_W-1:0]         mem_waddr;
    logic                      mem_we;
    logic [DATA_W-1:0]         mem_din;
    logic [DATA_W-1:0]         mem_dout;
    logic                      busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, mem_raddr, mem_waddr, mem_we, mem_din, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, mem_raddr, mem_waddr, mem_we, mem_din, busy
    );
endinterface

`default_nettype wire

// File: rtl/bram_port_arbiter_rr_grant.sv
// ============================================================================
// Module : rr_grant
// Brief  : Round-robin priority picker; search starts at i_ptr and wraps.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_grant
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    // First pass covers ptr..N-1, second pass the wrapped part 0..ptr-1.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_valid[i] && (PTR_W'(i) >= i_ptr)) begin
                o_grant[i] = 1'b1;
                o_idx      = PTR_W'(i);
                o_any      = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_valid[i]) begin
                o_grant[i] = 1'b1;
                o_idx      = PTR_W'(i);
                o_any      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bram_port_arbiter.sv
// ============================================================================
// Module : bram_port_arbiter
// Brief  : Round-robin sharing of one simple-dual-port BRAM among NUM_REQ
//          requesters. Define BRAM_ARB_CLEAR_EN for a zeroing sweep on reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 1,
    parameter int DEPTH   = 128
) (
    input  logic              clk,
    input  logic              reset,
    bram_port_arbiter_if.slave bus
);

    localparam int               c_ptr_w = $clog2(NUM_REQ);
    localparam logic [ADDR_W:0]  c_depth = (ADDR_W+1)'(DEPTH);
`ifdef BRAM_ARB_CLEAR_EN
    localparam logic [ADDR_W-1:0] c_last      = ADDR_W'(DEPTH - 1);
    localparam arb_state_t        c_rst_state = ST_CLEAR;
`else
    localparam arb_state_t        c_rst_state = ST_RUN;
`endif

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [c_ptr_w-1:0]  r_rr_ptr;
    logic [c_ptr_w-1:0]  w_gnt_idx;
    logic [NUM_REQ-1:0]  w_cand;
    logic [NUM_REQ-1:0]  w_gnt;
    logic                w_gnt_any;
    logic                w_run;
    logic                w_sel_we;
    logic                w_in_range;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [ADDR_W-1:0]   r_raddr;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_din;
    logic [ADDR_W-1:0]   w_raddr;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_din;
    logic                w_we;
    logic                r_rsp_pend;
    logic                r_rsp_oor;
    logic [c_ptr_w-1:0]  r_rsp_id;
    logic [NUM_REQ-1:0]  w_rsp_valid;
`ifdef BRAM_ARB_CLEAR_EN
    logic [ADDR_W-1:0]   r_clr_cnt;
`endif

    // Nothing is granted while reset is held, so reset values hold on outputs.
    assign w_run  = (r_state == ST_RUN) && !reset;
    assign w_cand = w_run ? bus.req_valid : '0;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (c_ptr_w)
    ) u_rr_grant (
        .i_valid (w_cand),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_gnt),
        .o_idx   (w_gnt_idx),
        .o_any   (w_gnt_any)
    );

    assign w_sel_addr  = bus.req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = bus.req_wdata[int'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_sel_we    = bus.req_we[w_gnt_idx];
    assign w_in_range  = {1'b0, w_sel_addr} < c_depth;

    // Next state and memory-port drive; idle cycles hold the last address/data.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_raddr     = r_raddr;
        w_waddr     = r_waddr;
        w_din       = r_din;
        case (r_state)
            ST_RUN: begin
                if (w_gnt_any) begin
                    if (w_sel_we) begin
                        w_we    = w_in_range;
                        w_waddr = w_sel_addr;
                        w_din   = w_sel_wdata;
                    end else begin
                        w_raddr = w_sel_addr;
                    end
                end
            end
`ifdef BRAM_ARB_CLEAR_EN
            ST_CLEAR: begin
                w_we    = !reset;
                w_waddr = r_clr_cnt;
                w_din   = '0;
                if (r_clr_cnt == c_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
`endif
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_rst_state;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_raddr    <= '0;
            r_waddr    <= '0;
            r_din      <= '0;
            r_rsp_pend <= 1'b0;
            r_rsp_oor  <= 1'b0;
            r_rsp_id   <= '0;
        end else begin
            r_raddr    <= w_raddr;
            r_waddr    <= w_waddr;
            r_din      <= w_din;
            r_rsp_pend <= w_gnt_any && !w_sel_we;
            r_rsp_oor  <= !w_in_range;
            r_rsp_id   <= w_gnt_idx;
            if (w_gnt_any) begin
                r_rr_ptr <= c_ptr_w'(rr_next(32'(w_gnt_idx), 32'(NUM_REQ)));
            end
        end
    end

`ifdef BRAM_ARB_CLEAR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
        end
    end
`endif

    // A response due while reset is asserted is dropped.
    always_comb begin
        w_rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rsp_valid[i] = r_rsp_pend && !reset && (r_rsp_id == c_ptr_w'(i));
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = r_rsp_oor ? '0 : bus.mem_dout;
    assign bus.mem_raddr = w_raddr;
    assign bus.mem_waddr = w_waddr;
    assign bus.mem_we    = w_we;
    assign bus.mem_din   = w_din;
    assign bus.busy      = (r_state == ST_CLEAR) || r_rsp_pend;

endmodule

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
// ============================================================================
// Module : tb_bram_port_arbiter
// Brief  : Scoreboard bench; DUT A has DEPTH=128, DUT B DEPTH=100 for range
//          checks. Honours BRAM_ARB_CLEAR_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bram_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 7;
    localparam int DW = 1;
`ifdef BRAM_ARB_CLEAR_EN
    localparam logic c_busy_rst  = 1'b1;
    localparam logic c_post_data = 1'b0;
`else
    localparam logic c_busy_rst  = 1'b0;
    localparam logic c_post_data = 1'b1;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic bd_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
    bram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

    bram_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .DEPTH(128)) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    bram_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .DEPTH(100)) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    // Read-first registered memories
    logic [DW-1:0] mem_a [0:127] = '{default: '0};
    logic [DW-1:0] mem_b [0:127] = '{default: '0};

    always @(posedge clk) begin
        if (bus_a.mem_we) mem_a[bus_a.mem_waddr] <= bus_a.mem_din;
        if (bd_en)        mem_a[5] <= 1'b1;
        bus_a.mem_dout <= mem_a[bus_a.mem_raddr];
    end

    always @(posedge clk) begin
        if (bus_b.mem_we) mem_b[bus_b.mem_waddr] <= bus_b.mem_din;
        if (bd_en)        mem_b[110] <= 1'b1;
        bus_b.mem_dout <= mem_b[bus_b.mem_raddr];
    end

    typedef struct {int id; logic [DW-1:0] d; int cyc;} exp_t;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea;
    exp_t eb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_a(input logic [1:0] v, input logic [1:0] we,
                           input logic [6:0] a1, input logic [6:0] a0, input logic [1:0] wd);
        bus_a.req_valid = v;
        bus_a.req_we    = we;
        bus_a.req_addr  = {a1, a0};
        bus_a.req_wdata = wd;
    endtask

    task automatic drive_b(input logic [1:0] v, input logic [1:0] we,
                           input logic [6:0] a1, input logic [6:0] a0, input logic [1:0] wd);
        bus_b.req_valid = v;
        bus_b.req_we    = we;
        bus_b.req_addr  = {a1, a0};
        bus_b.req_wdata = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int id, input logic d);
        q_a.push_back('{id: id, d: d, cyc: cyc + 1});
    endtask

    task automatic push_b(input int id, input logic d);
        q_b.push_back('{id: id, d: d, cyc: cyc + 1});
    endtask

    // Monitor: compare every presented response against the queue heads
    always @(negedge clk) begin
        while (q_a.size() > 0 && q_a[0].cyc < cyc) begin
            ea = q_a.pop_front();
            n_tests++; n_fail++;
            $display("FAIL rsp_a_missing: actual none, required id %0d at cycle %0d", ea.id, ea.cyc);
        end
        while (q_b.size() > 0 && q_b[0].cyc < cyc) begin
            eb = q_b.pop_front();
            n_tests++; n_fail++;
            $display("FAIL rsp_b_missing: actual none, required id %0d at cycle %0d", eb.id, eb.cyc);
        end
        if (bus_a.rsp_valid != '0) begin
            if (q_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rsp_a_unexpected: actual rsp_valid %b, required 00", bus_a.rsp_valid);
            end else begin
                ea = q_a.pop_front();
                chk("rsp_a_valid", 32'(bus_a.rsp_valid), 32'(1) << ea.id);
                chk("rsp_a_rdata", 32'(bus_a.rsp_rdata), 32'(ea.d));
                chk("rsp_a_cycle", cyc, ea.cyc);
            end
        end
        if (bus_b.rsp_valid != '0) begin
            if (q_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rsp_b_unexpected: actual rsp_valid %b, required 00", bus_b.rsp_valid);
            end else begin
                eb = q_b.pop_front();
                chk("rsp_b_valid", 32'(bus_b.rsp_valid), 32'(1) << eb.id);
                chk("rsp_b_rdata", 32'(bus_b.rsp_rdata), 32'(eb.d));
                chk("rsp_b_cycle", cyc, eb.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_g;
        int         w;
        drive_a(2'b00, 2'b00, 7'd0, 7'd0, 2'b00);
        drive_b(2'b00, 2'b00, 7'd0, 7'd0, 2'b00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready",  32'(bus_a.req_ready), 0);
        chk("reset_rsp",    32'(bus_a.rsp_valid), 0);
        chk("reset_we",     32'(bus_a.mem_we), 0);
        chk("reset_raddr",  32'(bus_a.mem_raddr), 0);
        chk("reset_waddr",  32'(bus_a.mem_waddr), 0);
        chk("reset_din",    32'(bus_a.mem_din), 0);
        chk("reset_busy",   32'(bus_a.busy), 32'(c_busy_rst));
        step();
        reset = 1'b0;

`ifdef BRAM_ARB_CLEAR_EN
        drive_a(2'b01, 2'b00, 7'd0, 7'd9, 2'b00);
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            chk("sweep_ready", 32'(bus_a.req_ready), 0);
            chk("sweep_we",    32'(bus_a.mem_we), 1);
            chk("sweep_waddr", 32'(bus_a.mem_waddr), i);
            if (i == 127) drive_a(2'b00, 2'b00, 7'd0, 7'd0, 2'b00);
            step();
        end
        @(negedge clk);
        chk("sweep_busy_done", 32'(bus_a.busy), 0);
        step();
`endif

        bd_en = 1'b1;
        step();
        bd_en = 1'b0;

        // Contention: both read every cycle, grants alternate from req0
        drive_a(2'b11, 2'b00, 7'd6, 7'd5, 2'b00);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("contention_grant", 32'(bus_a.req_ready), 32'(exp_g));
            push_a(k % 2, (k % 2 == 0) ? 1'b1 : 1'b0);
            step();
        end
        drive_a(2'b00, 2'b00, 7'd0, 7'd0, 2'b00);

        // Single read of preloaded address 5
        drive_a(2'b01, 2'b00, 7'd0, 7'd5, 2'b00);
        @(negedge clk);
        chk("single_ready", 32'(bus_a.req_ready), 32'(2'b01));
        chk("single_raddr", 32'(bus_a.mem_raddr), 5);
        chk("single_we",    32'(bus_a.mem_we), 0);
        push_a(0, 1'b1);
        step();
        drive_a(2'b00, 2'b00, 7'd0, 7'd0, 2'b00);
        @(negedge clk);
        chk("single_busy", 32'(bus_a.busy), 1);
        step();
        @(negedge clk);
        chk("idle_busy",       32'(bus_a.busy), 0);
        chk("idle_raddr_hold", 32'(bus_a.mem_raddr), 5);
        step();

        // Write 127 by req1, then read it back by req0
        drive_a(2'b10, 2'b10, 7'd127, 7'd0, 2'b10);
        @(negedge clk);
        chk("wr_ready", 32'(bus_a.req_ready), 32'(2'b10));
        chk("wr_we",    32'(bus_a.mem_we), 1);
        chk("wr_waddr", 32'(bus_a.mem_waddr), 127);
        chk("wr_din",   32'(bus_a.mem_din), 1);
        step();
        drive_a(2'b01, 2'b00, 7'd0, 7'd127, 2'b00);
        @(negedge clk);
        chk("rbw_ready", 32'(bus_a.req_ready), 32'(2'b01));
        chk("rbw_raddr", 32'(bus_a.mem_raddr), 127);
        push_a(0, 1'b1);
        step();

        // Pointer at 1, only req0 valid: wraps to req0
        drive_a(2'b01, 2'b00, 7'd0, 7'd6, 2'b00);
        @(negedge clk);
        chk("wrap_ready", 32'(bus_a.req_ready), 32'(2'b01));
        push_a(0, 1'b0);
        step();

        // Pointer at 1, both valid: req1 wins
        drive_a(2'b11, 2'b00, 7'd5, 7'd6, 2'b00);
        @(negedge clk);
        chk("ptr1_ready", 32'(bus_a.req_ready), 32'(2'b10));
        push_a(1, 1'b1);
        step();
        drive_a(2'b00, 2'b00, 7'd0, 7'd0, 2'b00);
        step();
        step();

        // Out-of-range on DEPTH=100 instance
        drive_b(2'b01, 2'b01, 7'd0, 7'd110, 2'b01);
        @(negedge clk);
        chk("oor_wr_ready", 32'(bus_b.req_ready), 32'(2'b01));
        chk("oor_wr_we",    32'(bus_b.mem_we), 0);
        step();
        drive_b(2'b01, 2'b00, 7'd0, 7'd110, 2'b00);
        @(negedge clk);
        chk("oor_rd_ready", 32'(bus_b.req_ready), 32'(2'b01));
        chk("oor_rd_raddr", 32'(bus_b.mem_raddr), 110);
        push_b(0, 1'b0);
        step();
        drive_b(2'b10, 2'b10, 7'd50, 7'd0, 2'b10);
        @(negedge clk);
        chk("inr_wr_we",    32'(bus_b.mem_we), 1);
        chk("inr_wr_waddr", 32'(bus_b.mem_waddr), 50);
        step();
        drive_b(2'b00, 2'b00, 7'd0, 7'd0, 2'b00);
        step();
        step();

        // Reset the cycle after a read is accepted
        drive_a(2'b01, 2'b00, 7'd0, 7'd5, 2'b00);
        @(negedge clk);
        chk("rst_rd_ready", 32'(bus_a.req_ready), 32'(2'b01));
        step();
        drive_a(2'b00, 2'b00, 7'd0, 7'd0, 2'b00);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rsp_drop", 32'(bus_a.rsp_valid), 0);
        step();
        @(negedge clk);
        chk("rst_rsp_after", 32'(bus_a.rsp_valid), 0);
        step();
        reset = 1'b0;
        w = 0;
        while (bus_a.busy && w < 400) begin
            step();
            w++;
        end
        chk("rst_busy_clear", 32'(bus_a.busy), 0);
        drive_a(2'b11, 2'b00, 7'd6, 7'd5, 2'b00);
        @(negedge clk);
        chk("post_reset_grant", 32'(bus_a.req_ready), 32'(2'b01));
        push_a(0, c_post_data);
        step();
        drive_a(2'b00, 2'b00, 7'd0, 7'd0, 2'b00);
        step();
        step();

        @(negedge clk);
        chk("queue_a_empty", q_a.size(), 0);
        chk("queue_b_empty", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
